// File: rtl/qspi_cmd_if.sv
// Signal bundle between the QSPI command engine and its surroundings:
// bus FIFOs, the 32-bit register port, the byte-wide memory port and status.
interface qspi_cmd_if #(
  parameter int ADDR_W = 24
);
  // request FIFO (consumer side) and response FIFO (producer side)
  logic              rd_empty;
  logic [7:0]        rd_data;
  logic              rd_en;
  logic              wr_full;
  logic              wr_en;
  logic [7:0]        wr_data;

  logic [7:0]        reg_addr;
  logic [31:0]       reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [31:0]       reg_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;

  logic              busy;
  logic              cmd_err;

  modport master (
    input  rd_empty, rd_data, wr_full, reg_rdata,
           mem_ready, mem_rvalid, mem_rdata,
    output rd_en, wr_en, wr_data, reg_addr, reg_wdata, reg_we, reg_re,
           mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
  );

  modport slave (
    output rd_empty, rd_data, wr_full, reg_rdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  rd_en, wr_en, wr_data, reg_addr, reg_wdata, reg_we, reg_re,
           mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
  );
endinterface

// File: rtl/qspi_cmd.sv
// Packet decoder behind the QSPI slave: pops request bytes, executes register
// and memory read/write commands, and pushes read results back to the MCU.
module qspi_cmd #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 16
) (
  input  logic       clk,
  input  logic       reset,
  qspi_cmd_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR,
    S_REG_WR,
    S_REG_RD,
    S_REG_SEND,
    S_MEM_WR_POP,
    S_MEM_WR_REQ,
    S_MEM_RD_REQ,
    S_MEM_RD_WAIT,
    S_MEM_RD_SEND
  } state_e;

  typedef enum logic [1:0] {
    OP_REG_WR,
    OP_REG_RD,
    OP_MEM_WR,
    OP_MEM_RD
  } op_e;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              cap_q, cap_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic [31:0]       reg_wdata_q, reg_wdata_d;
  logic [23:0]       rdata_q, rdata_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              en_q;

  logic              rd_en, wr_en, reg_we, reg_re, mem_we, mem_re, cmd_err;
  logic              rd_ok, wr_ok;
  logic [2:0]        hidx;

  function automatic logic [ADDR_W-1:0] put_addr_byte(input logic [ADDR_W-1:0] v,
                                                      input int k,
                                                      input logic [7:0] b);
    logic [ADDR_W-1:0] r;
    r = v;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i / 8 == k) r[i] = b[i[2:0]];
    end
    return r;
  endfunction

  function automatic logic [LEN_W-1:0] put_len_byte(input logic [LEN_W-1:0] v,
                                                    input int k,
                                                    input logic [7:0] b);
    logic [LEN_W-1:0] r;
    r = v;
    for (int i = 0; i < LEN_W; i++) begin
      if (i / 8 == k) r[i] = b[i[2:0]];
    end
    return r;
  endfunction

  // en_q keeps the FIFO pop strobe quiet while reset is asserted
  assign rd_ok = en_q && !bus.rd_empty;
  assign wr_ok = !bus.wr_full;
  assign hidx  = (op_q == OP_REG_RD) ? 3'd0 : 3'd5 - cnt_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    bcnt_d      = bcnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rdata_d     = rdata_q;
    wr_data_d   = wr_data_q;
    mem_wdata_d = mem_wdata_q;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    reg_we      = 1'b0;
    reg_re      = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    cmd_err     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rd_ok) begin
          rd_en = 1'b1;
          unique case (bus.rd_data)
            8'h10: begin op_d = OP_REG_WR; cnt_d = 3'd5; state_d = S_HDR; end
            8'h11: begin op_d = OP_REG_RD; cnt_d = 3'd1; state_d = S_HDR; end
            8'h20: begin op_d = OP_MEM_WR; cnt_d = 3'd5; state_d = S_HDR; end
            8'h21: begin op_d = OP_MEM_RD; cnt_d = 3'd5; state_d = S_HDR; end
            default: cmd_err = 1'b1;
          endcase
        end
      end

      S_HDR: begin
        if (rd_ok) begin
          rd_en = 1'b1;
          cnt_d = cnt_q - 3'd1;
          unique case (op_q)
            OP_REG_WR: begin
              unique case (hidx)
                3'd0:    reg_addr_d         = bus.rd_data;
                3'd1:    reg_wdata_d[7:0]   = bus.rd_data;
                3'd2:    reg_wdata_d[15:8]  = bus.rd_data;
                3'd3:    reg_wdata_d[23:16] = bus.rd_data;
                default: reg_wdata_d[31:24] = bus.rd_data;
              endcase
            end
            OP_REG_RD: reg_addr_d = bus.rd_data;
            default: begin
              // memory headers: a0..a2 then l0..l1, little-endian
              if (hidx < 3'd3) addr_d = put_addr_byte(addr_q, int'(hidx), bus.rd_data);
              else             len_d  = put_len_byte(len_q, int'(hidx) - 3, bus.rd_data);
            end
          endcase
          if (cnt_q == 3'd1) begin
            unique case (op_q)
              OP_REG_WR: state_d = S_REG_WR;
              OP_REG_RD: state_d = S_REG_RD;
              OP_MEM_WR: state_d = (len_d == '0) ? S_IDLE : S_MEM_WR_POP;
              default:   state_d = (len_d == '0) ? S_IDLE : S_MEM_RD_REQ;
            endcase
          end
        end
      end

      S_REG_WR: begin
        reg_we  = 1'b1;
        state_d = S_IDLE;
      end

      S_REG_RD: begin
        reg_re  = 1'b1;
        cap_d   = 1'b1;
        state_d = S_REG_SEND;
      end

      S_REG_SEND: begin
        // first cycle here only latches reg_rdata; pushes start the cycle after
        if (cap_q) begin
          cap_d     = 1'b0;
          bcnt_d    = 2'd0;
          wr_data_d = bus.reg_rdata[7:0];
          rdata_d   = bus.reg_rdata[31:8];
        end else if (wr_ok) begin
          wr_en     = 1'b1;
          wr_data_d = rdata_q[7:0];
          rdata_d   = {8'h00, rdata_q[23:8]};
          bcnt_d    = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_IDLE;
        end
      end

      S_MEM_WR_POP: begin
        if (rd_ok) begin
          rd_en       = 1'b1;
          mem_wdata_d = bus.rd_data;
          state_d     = S_MEM_WR_REQ;
        end
      end

      S_MEM_WR_REQ: begin
        mem_we = 1'b1;
        if (bus.mem_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q - LEN_W'(1);
          state_d = (len_q == LEN_W'(1)) ? S_IDLE : S_MEM_WR_POP;
        end
      end

      S_MEM_RD_REQ: begin
        mem_re = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_RD_WAIT;
      end

      S_MEM_RD_WAIT: begin
        if (bus.mem_rvalid) begin
          wr_data_d = bus.mem_rdata;
          state_d   = S_MEM_RD_SEND;
        end
      end

      S_MEM_RD_SEND: begin
        if (wr_ok) begin
          wr_en   = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          len_d   = len_q - LEN_W'(1);
          state_d = (len_q == LEN_W'(1)) ? S_IDLE : S_MEM_RD_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_REG_WR;
      cnt_q       <= 3'd0;
      cap_q       <= 1'b0;
      bcnt_q      <= 2'd0;
      addr_q      <= '0;
      len_q       <= '0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 32'h0;
      rdata_q     <= 24'h0;
      wr_data_q   <= 8'h00;
      mem_wdata_q <= 8'h00;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      bcnt_q      <= bcnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rdata_q     <= rdata_d;
      wr_data_q   <= wr_data_d;
      mem_wdata_q <= mem_wdata_d;
      en_q        <= 1'b1;
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.wr_en     = wr_en;
  assign bus.wr_data   = wr_data_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_we    = reg_we;
  assign bus.reg_re    = reg_re;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.cmd_err   = cmd_err;

endmodule

// File: tb/tb_qspi_cmd.sv
// Directed bench for qspi_cmd: a cycle model of the FIFOs, register port and
// memory drives the DUT while hand-computed results are compared.
module tb_qspi_cmd;

  logic clk;
  logic reset;

  qspi_cmd_if #(.ADDR_W(24)) bus ();

  qspi_cmd #(.ADDR_W(24), .LEN_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec, n_miss;
  int          cyc_no;
  logic [7:0]  req_q[$];
  logic [7:0]  resp_q[$];
  logic [31:0] wlog[$];
  int          wcyc[$];
  logic [7:0]  mem[logic [23:0]];

  int          first_pop, last_pop, busy_rise, we_cyc, re_cyc, first_push;
  int          n_we, n_re, n_err, n_mw, n_mr, n_both, n_unstable;
  logic [7:0]  last_waddr, last_raddr;
  logic [31:0] last_wdata;
  logic        hold_chk;
  logic [33:0] hold_val;

  int          ready_delay, ready_cnt, rv_lat, rv_cnt, full_at, full_cnt;
  logic        full_arm, gap_mode;
  logic [23:0] rv_addr;
  logic [31:0] reg_val;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    first_pop = -1; last_pop = -1; busy_rise = -1;
    we_cyc = -1; re_cyc = -1; first_push = -1;
    n_we = 0; n_re = 0; n_err = 0; n_mw = 0; n_mr = 0;
    hold_chk = 1'b0;
    resp_q.delete(); wlog.delete(); wcyc.delete();
  endtask

  task automatic set_ready(input int d);
    ready_delay   = d;
    ready_cnt     = d;
    bus.mem_ready = (d == 0);
  endtask

  // observe at negedge, then update the environment just after posedge
  task automatic cyc();
    logic pop, acc_w, acc_r, saw_re, req;
    @(negedge clk);
    cyc_no++;
    pop = bus.rd_en;
    if (pop) begin
      if (first_pop < 0) first_pop = cyc_no;
      last_pop = cyc_no;
    end
    if (bus.busy && busy_rise < 0) busy_rise = cyc_no;
    if (bus.rd_en && bus.wr_en) n_both++;
    if (bus.wr_en) begin
      resp_q.push_back(bus.wr_data);
      if (first_push < 0) first_push = cyc_no;
    end
    if (bus.reg_we) begin
      n_we++; we_cyc = cyc_no;
      last_waddr = bus.reg_addr; last_wdata = bus.reg_wdata;
    end
    saw_re = bus.reg_re;
    if (saw_re) begin n_re++; re_cyc = cyc_no; last_raddr = bus.reg_addr; end
    if (bus.cmd_err) n_err++;
    req = bus.mem_we || bus.mem_re;
    if (hold_chk && hold_val != {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata})
      n_unstable++;
    hold_chk = req && !bus.mem_ready;
    hold_val = {bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata};
    acc_w = bus.mem_we && bus.mem_ready;
    acc_r = bus.mem_re && bus.mem_ready;
    if (acc_w) begin
      n_mw++;
      wlog.push_back({bus.mem_addr, bus.mem_wdata});
      wcyc.push_back(cyc_no);
      mem[bus.mem_addr] = bus.mem_wdata;
    end
    if (acc_r) begin n_mr++; rv_addr = bus.mem_addr; end

    @(posedge clk);
    #1;
    if (pop && req_q.size() > 0) req_q.delete(0);
    bus.reg_rdata = saw_re ? reg_val : 32'h0BAD_F00D;
    if (acc_w || acc_r) ready_cnt = ready_delay;
    else if (req && ready_cnt > 0) ready_cnt--;
    bus.mem_ready = (ready_cnt == 0);
    if (acc_r) rv_cnt = rv_lat;
    if (rv_cnt > 0) begin
      rv_cnt--;
      bus.mem_rvalid = (rv_cnt == 0);
    end else begin
      bus.mem_rvalid = 1'b0;
    end
    bus.mem_rdata = !bus.mem_rvalid ? 8'h5A : (mem.exists(rv_addr) ? mem[rv_addr] : 8'h00);
    if (full_arm && resp_q.size() == full_at) begin
      full_cnt = 5;
      full_arm = 1'b0;
    end
    bus.wr_full = (full_cnt > 0);
    if (full_cnt > 0) full_cnt--;
    bus.rd_empty = (req_q.size() == 0) || (gap_mode && cyc_no[0]);
    bus.rd_data  = (req_q.size() > 0) ? req_q[0] : 8'h00;
  endtask

  task automatic run_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cyc();
      if (req_q.size() == 0 && !bus.busy) done = 1'b1;
    end
    check_val({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_outs_zero(input string tag);
    check_val({tag, "_ctl"}, {bus.rd_en, bus.wr_en, bus.reg_we, bus.reg_re,
                              bus.mem_we, bus.mem_re, bus.busy, bus.cmd_err}, 64'd0);
    check_val({tag, "_reg"}, {bus.reg_addr, bus.reg_wdata}, 64'd0);
    check_val({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata, bus.wr_data}, 64'd0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; cyc_no = 0; n_both = 0; n_unstable = 0;
    rv_lat = 1; rv_cnt = 0; full_arm = 1'b0; full_at = 0; full_cnt = 0;
    gap_mode = 1'b0; reg_val = 32'h0; rv_addr = 24'h0;
    last_waddr = 8'h0; last_raddr = 8'h0; last_wdata = 32'h0; hold_val = '0;
    reset = 1'b0;
    bus.rd_empty = 1'b1; bus.rd_data = 8'h00; bus.wr_full = 1'b0;
    bus.reg_rdata = 32'h0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 8'h00;
    set_ready(0);
    clr_stats();
    repeat (3) cyc();
    check_outs_zero("reset");
    reset = 1'b1;

    // REG_WR
    clr_stats();
    req_q = '{8'h10, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_idle("regwr", 50);
    check_val("regwr_we_cnt", 64'(n_we), 64'd1);
    check_val("regwr_addr", 64'(last_waddr), 64'h05);
    check_val("regwr_data", 64'(last_wdata), 64'hDEADBEEF);
    check_val("regwr_we_lat", 64'(we_cyc - last_pop), 64'd1);
    check_val("regwr_busy_rise", 64'(busy_rise - first_pop), 64'd1);
    check_val("regwr_busy_end", 64'(bus.busy), 64'd0);

    // REG_RD
    clr_stats();
    reg_val = 32'h12345678;
    req_q = '{8'h11, 8'h3A};
    run_idle("regrd", 50);
    check_val("regrd_re_cnt", 64'(n_re), 64'd1);
    check_val("regrd_addr", 64'(last_raddr), 64'h3A);
    check_val("regrd_re_lat", 64'(re_cyc - last_pop), 64'd1);
    check_val("regrd_push_lat", 64'(first_push - re_cyc), 64'd2);
    check_val("regrd_nbytes", 64'(resp_q.size()), 64'd4);
    check_val("regrd_bytes", {resp_q[0], resp_q[1], resp_q[2], resp_q[3]}, 64'h78563412);

    // MEM_WR with address wrap and slow mem_ready
    clr_stats();
    set_ready(3);
    req_q = '{8'h20, 8'hFE, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    run_idle("memwr", 200);
    check_val("memwr_cnt", 64'(n_mw), 64'd3);
    check_val("memwr_w0", 64'(wlog[0]), 64'hFFFFFEAA);
    check_val("memwr_w1", 64'(wlog[1]), 64'hFFFFFFBB);
    check_val("memwr_w2", 64'(wlog[2]), 64'h000000CC);

    // MEM_WR throughput with mem_ready high
    clr_stats();
    set_ready(0);
    req_q = '{8'h20, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_idle("memtp", 100);
    check_val("memtp_cnt", 64'(n_mw), 64'd4);
    check_val("memtp_span", 64'(wcyc[3] - wcyc[0]), 64'd6);
    check_val("memtp_last", 64'(wlog[3]), 64'h00020304);

    // MEM_RD with read latency and a response-FIFO stall mid-burst
    clr_stats();
    mem[24'h001000] = 8'h11; mem[24'h001001] = 8'h22;
    mem[24'h001002] = 8'h33; mem[24'h001003] = 8'h44;
    rv_lat = 2; full_at = 2; full_arm = 1'b1;
    req_q = '{8'h21, 8'h00, 8'h10, 8'h00, 8'h04, 8'h00};
    run_idle("memrd", 200);
    check_val("memrd_reads", 64'(n_mr), 64'd4);
    check_val("memrd_nbytes", 64'(resp_q.size()), 64'd4);
    check_val("memrd_bytes", {resp_q[0], resp_q[1], resp_q[2], resp_q[3]}, 64'h11223344);

    // unknown opcode then REG_WR, with gaps in the request FIFO
    clr_stats();
    gap_mode = 1'b1;
    req_q = '{8'h7F, 8'h10, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run_idle("unk", 100);
    check_val("unk_err_cnt", 64'(n_err), 64'd1);
    check_val("unk_we_cnt", 64'(n_we), 64'd1);
    check_val("unk_wr", {last_waddr, last_wdata}, 64'h01_00000000);
    gap_mode = 1'b0;

    // MEM_WR with LEN 0
    clr_stats();
    req_q = '{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_idle("len0", 50);
    check_val("len0_mw_cnt", 64'(n_mw), 64'd0);

    // reset during the MEM_WR data phase
    clr_stats();
    set_ready(3);
    req_q = '{8'h20, 8'h00, 8'h30, 8'h00, 8'h04, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    for (int i = 0; i < 200 && n_mw == 0; i++) cyc();
    check_val("rstmid_first_wr", 64'(wlog[0]), 64'h003000A1);
    #2 reset = 1'b0;
    #1;
    check_outs_zero("rstmid");
    req_q.delete();
    repeat (2) cyc();
    reset = 1'b1;
    clr_stats();
    reg_val = 32'hCAFEF00D;
    req_q = '{8'h11, 8'h00};
    run_idle("after_rst", 50);
    check_val("after_rst_re", 64'(n_re), 64'd1);
    check_val("after_rst_strobes", 64'(n_we + n_mw), 64'd0);
    check_val("after_rst_bytes", {resp_q[0], resp_q[1], resp_q[2], resp_q[3]}, 64'h0DF0FECA);

    check_val("rd_wr_overlap", 64'(n_both), 64'd0);
    check_val("mem_req_unstable", 64'(n_unstable), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
